// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding bus access per memory instruction.
// Define LSU_MISALIGN_TRAP_EN to complete misaligned accesses without a bus request.
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mtype_i,
   input  logic        ex_mem_rw_i,
   input  logic [1:0]  ex_mem_width_i,
   input  logic        ex_mem_rdtype_i,
   input  logic [31:0] ex_addr_i,
   input  logic [31:0] ex_wdata_i,
   output logic        lsu_stall_o,
   output logic        lsu_done_o,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_misalign_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

   state_e      state_q;
   logic        rw_q;
   logic [1:0]  width_q;
   logic        rdtype_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        done_q;
   logic        req_q;
   logic        ex_req;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_d;

   assign ex_req = ex_mtype_i && (ex_mem_width_i != 2'd0);

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;
   logic ex_mis;
   assign ex_mis = ((ex_mem_width_i == 2'd2) && ex_addr_i[0]) ||
                   ((ex_mem_width_i == 2'd3) && (ex_addr_i[1:0] != 2'd0));
   assign lsu_misalign_o = mis_q;
`else
   assign lsu_misalign_o = 1'b0;
`endif

   assign lsu_stall_o = ((state_q == IDLE) && ex_req) ||
                        (state_q == REQ) || (state_q == WAIT);
   assign lsu_done_o  = done_q;
   assign lsu_rdata_o = rdata_q;
   assign bus_req_o   = req_q;
   assign bus_we_o    = ~rw_q;
   assign bus_addr_o  = {addr_q[31:2], 2'b00};

   always_comb begin
      bus_be_o    = 4'b0000;
      bus_wdata_o = wdata_q;
      unique case (width_q)
         2'd1: begin
            bus_be_o    = 4'b0001 << addr_q[1:0];
            bus_wdata_o = {4{wdata_q[7:0]}};
         end
         2'd2: begin
            bus_be_o    = 4'b0011 << {addr_q[1], 1'b0};
            bus_wdata_o = {2{wdata_q[15:0]}};
         end
         2'd3: bus_be_o = 4'b1111;
         2'd0: bus_be_o = 4'b0000;
      endcase
   end

   // Lane select follows the latched address; misaligned halves use {addr[1],0}.
   always_comb begin
      ld_b = bus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
      ld_h = bus_rdata_i[{addr_q[1], 4'b0000} +: 16];
      ld_d = bus_rdata_i;
      unique case (width_q)
         2'd1: ld_d = rdtype_q ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
         2'd2: ld_d = rdtype_q ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
         default: ld_d = bus_rdata_i;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rw_q     <= 1'b0;
         width_q  <= 2'd0;
         rdtype_q <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         done_q   <= 1'b0;
         req_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q  <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (ex_req) begin
                  rw_q     <= ex_mem_rw_i;
                  width_q  <= ex_mem_width_i;
                  rdtype_q <= ex_mem_rdtype_i;
                  addr_q   <= ex_addr_i;
                  wdata_q  <= ex_wdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
                  if (ex_mis) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     mis_q   <= 1'b1;
                  end else begin
                     state_q <= REQ;
                     req_q   <= 1'b1;
                  end
`else
                  state_q <= REQ;
                  req_q   <= 1'b1;
`endif
               end
            end
            REQ: begin
               if (bus_gnt_i) begin
                  req_q <= 1'b0;
                  if (bus_rvalid_i) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     if (rw_q) rdata_q <= ld_d;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (bus_rvalid_i) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  if (rw_q) rdata_q <= ld_d;
               end
            end
            DONE: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: expected completions queued at issue,
// checked by a monitor on every done pulse.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_mtype_i;
   logic        ex_mem_rw_i;
   logic [1:0]  ex_mem_width_i;
   logic        ex_mem_rdtype_i;
   logic [31:0] ex_addr_i;
   logic [31:0] ex_wdata_i;
   logic        lsu_stall_o;
   logic        lsu_done_o;
   logic [31:0] lsu_rdata_o;
   logic        lsu_misalign_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_gnt_i;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;

   lsu_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .ex_mtype_i     (ex_mtype_i),
      .ex_mem_rw_i    (ex_mem_rw_i),
      .ex_mem_width_i (ex_mem_width_i),
      .ex_mem_rdtype_i(ex_mem_rdtype_i),
      .ex_addr_i      (ex_addr_i),
      .ex_wdata_i     (ex_wdata_i),
      .lsu_stall_o    (lsu_stall_o),
      .lsu_done_o     (lsu_done_o),
      .lsu_rdata_o    (lsu_rdata_o),
      .lsu_misalign_o (lsu_misalign_o),
      .bus_req_o      (bus_req_o),
      .bus_we_o       (bus_we_o),
      .bus_addr_o     (bus_addr_o),
      .bus_be_o       (bus_be_o),
      .bus_wdata_o    (bus_wdata_o),
      .bus_gnt_i      (bus_gnt_i),
      .bus_rvalid_i   (bus_rvalid_i),
      .bus_rdata_i    (bus_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (lsu_done_o !== 1'b0) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: got done=%b expected no done at %0t",
                     lsu_done_o, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("done_rdata", lsu_rdata_o, mon_e.rdata);
            chk("done_misalign", {31'd0, lsu_misalign_o}, {31'd0, mon_e.mis});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic issue(input logic rw, input logic [1:0] w, input logic rd,
                        input logic [31:0] a, input logic [31:0] d);
      ex_mtype_i      = 1'b1;
      ex_mem_rw_i     = rw;
      ex_mem_width_i  = w;
      ex_mem_rdtype_i = rd;
      ex_addr_i       = a;
      ex_wdata_i      = d;
   endtask

   initial begin
      rst             = 1'b1;
      ex_mtype_i      = 1'b0;
      ex_mem_rw_i     = 1'b0;
      ex_mem_width_i  = 2'd0;
      ex_mem_rdtype_i = 1'b0;
      ex_addr_i       = 32'd0;
      ex_wdata_i      = 32'd0;
      bus_gnt_i       = 1'b0;
      bus_rvalid_i    = 1'b0;
      bus_rdata_i     = 32'd0;
      tick();
      tick();
      smp();
      chk("rst_rdata", lsu_rdata_o, 32'd0);
      chk("rst_done", lsu_done_o, 0);
      chk("rst_misalign", lsu_misalign_o, 0);
      chk("rst_req", bus_req_o, 0);
      chk("rst_stall", lsu_stall_o, 0);
      tick();
      rst = 1'b0;

      // LB 0x103, sign-extend, gnt first REQ cycle, rvalid two cycles later
      issue(1'b1, 2'd1, 1'b0, 32'h103, 32'd0);
      exp_q.push_back('{rdata: 32'hFFFFFF80, mis: 1'b0});
      smp();
      chk("lb_stall_idle", lsu_stall_o, 1);
      chk("lb_noreq_idle", bus_req_o, 0);
      tick();
      ex_mtype_i = 1'b0;
      bus_gnt_i  = 1'b1;
      smp();
      chk("lb_req", bus_req_o, 1);
      chk("lb_addr", bus_addr_o, 32'h100);
      chk("lb_be", bus_be_o, 4'b1000);
      chk("lb_we", bus_we_o, 0);
      chk("lb_stall_req", lsu_stall_o, 1);
      tick();
      bus_gnt_i = 1'b0;
      smp();
      chk("lb_req_wait", bus_req_o, 0);
      chk("lb_stall_wait", lsu_stall_o, 1);
      tick();
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h80FFFFFF;
      smp();
      chk("lb_stall_wait2", lsu_stall_o, 1);
      tick();
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = 32'd0;
      smp();
      chk("lb_done", lsu_done_o, 1);
      chk("lb_stall_done", lsu_stall_o, 0);
      tick();
      smp();
      chk("lb_done_single", lsu_done_o, 0);
      tick();

      // SH 0x202, grant held off three cycles
      issue(1'b0, 2'd2, 1'b0, 32'h202, 32'h1234ABCD);
      exp_q.push_back('{rdata: 32'hFFFFFF80, mis: 1'b0});
      tick();
      ex_mtype_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_gnt_i = (i == 3);
         smp();
         chk("sh_req", bus_req_o, 1);
         chk("sh_we", bus_we_o, 1);
         chk("sh_addr", bus_addr_o, 32'h200);
         chk("sh_be", bus_be_o, 4'b1100);
         chk("sh_wdata", bus_wdata_o, 32'hABCDABCD);
         tick();
      end
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b1;
      smp();
      chk("sh_req_wait", bus_req_o, 0);
      tick();
      bus_rvalid_i = 1'b0;
      smp();
      chk("sh_done", lsu_done_o, 1);
      tick();

      // LHU 0x10 with grant and rvalid together
      issue(1'b1, 2'd2, 1'b1, 32'h10, 32'd0);
      exp_q.push_back('{rdata: 32'h0000F00D, mis: 1'b0});
      tick();
      ex_mtype_i   = 1'b0;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'h0000F00D;
      smp();
      chk("lhu_req", bus_req_o, 1);
      tick();
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = 32'd0;
      smp();
      chk("lhu_done", lsu_done_o, 1);
      chk("lhu_stall", lsu_stall_o, 0);
      tick();

      // SB 0x1: byte lane replication
      issue(1'b0, 2'd1, 1'b0, 32'h1, 32'h000000A5);
      exp_q.push_back('{rdata: 32'h0000F00D, mis: 1'b0});
      tick();
      ex_mtype_i = 1'b0;
      bus_gnt_i  = 1'b1;
      smp();
      chk("sb_be", bus_be_o, 4'b0010);
      chk("sb_wdata", bus_wdata_o, 32'hA5A5A5A5);
      tick();
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b1;
      smp();
      tick();
      bus_rvalid_i = 1'b0;
      smp();
      tick();

      // Reset while waiting for the response, then a late rvalid
      issue(1'b1, 2'd3, 1'b0, 32'h20, 32'd0);
      tick();
      ex_mtype_i = 1'b0;
      bus_gnt_i  = 1'b1;
      smp();
      tick();
      bus_gnt_i = 1'b0;
      smp();
      chk("rw_stall_wait", lsu_stall_o, 1);
      rst = 1'b1;
      tick();
      rst          = 1'b0;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'hDEADBEEF;
      smp();
      chk("rw_req", bus_req_o, 0);
      chk("rw_stall", lsu_stall_o, 0);
      chk("rw_rdata", lsu_rdata_o, 32'd0);
      chk("rw_done", lsu_done_o, 0);
      tick();
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = 32'd0;
      smp();
      chk("rw_done2", lsu_done_o, 0);
      chk("rw_rdata2", lsu_rdata_o, 32'd0);
      tick();

      // LW 0x6: misaligned word
      issue(1'b1, 2'd3, 1'b0, 32'h6, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      exp_q.push_back('{rdata: 32'd0, mis: 1'b1});
      smp();
      chk("lwm_stall", lsu_stall_o, 1);
      chk("lwm_req_idle", bus_req_o, 0);
      tick();
      ex_mtype_i = 1'b0;
      smp();
      chk("lwm_req_done", bus_req_o, 0);
      chk("lwm_done", lsu_done_o, 1);
      tick();
      smp();
      chk("lwm_done_single", lsu_done_o, 0);
      tick();
`else
      exp_q.push_back('{rdata: 32'hCAFEF00D, mis: 1'b0});
      smp();
      chk("lwm_stall", lsu_stall_o, 1);
      tick();
      ex_mtype_i   = 1'b0;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'hCAFEF00D;
      smp();
      chk("lwm_req", bus_req_o, 1);
      chk("lwm_addr", bus_addr_o, 32'h4);
      chk("lwm_be", bus_be_o, 4'b1111);
      tick();
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = 32'd0;
      smp();
      chk("lwm_done", lsu_done_o, 1);
      tick();
`endif

      // Width 0 is a no-op
      issue(1'b1, 2'd0, 1'b0, 32'h40, 32'd0);
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("nop_stall", lsu_stall_o, 0);
         chk("nop_req", bus_req_o, 0);
         chk("nop_done", lsu_done_o, 0);
         tick();
      end
      ex_mtype_i = 1'b0;
      tick();
      smp();
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
